// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the memory port arbiter: length codes, FSM state
// encodings and owner codes.
package mem_port_arbiter_pkg;

   // Bus length codes (2 is reserved and forwarded unchanged)
   localparam logic [1:0] LEN_BYTE = 2'd0;
   localparam logic [1:0] LEN_HALF = 2'd1;
   localparam logic [1:0] LEN_WORD = 2'd3;

   // Arbiter FSM state encodings
   typedef logic [1:0] arb_state_t;
   localparam arb_state_t ARB_IDLE    = 2'd0;
   localparam arb_state_t ARB_GRANT   = 2'd1;
   localparam arb_state_t ARB_RELEASE = 2'd2;

   // Owner codes reported on the owner output
   localparam logic OWNER_IF  = 1'b0;
   localparam logic OWNER_MEM = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester handshakes, memory bus signals and status flags.
// slave: the arbiter side. master: pipeline stages plus memory model.
interface mem_port_arbiter_if #(
   parameter int ADDR_L = 32,
   parameter int DATA_L = 32
);
   // fetch requester
   logic              if_re;
   logic [ADDR_L-1:0] if_addr;
   logic [1:0]        if_rlen;
   logic              if_rack;
   logic [DATA_L-1:0] if_rdata;
   // load/store requester
   logic              mem_re;
   logic              mem_we;
   logic [ADDR_L-1:0] mem_addr;
   logic [1:0]        mem_len;
   logic [DATA_L-1:0] mem_wdata;
   logic              mem_ack;
   logic [DATA_L-1:0] mem_rdata;
   // memory bus
   logic              bus_re;
   logic              bus_we;
   logic [ADDR_L-1:0] bus_addr;
   logic [1:0]        bus_len;
   logic [DATA_L-1:0] bus_wdata;
   logic              bus_ack;
   logic [DATA_L-1:0] bus_rdata;
   // status
   logic              owner;
   logic              busy;
   logic              err;

   modport slave (
      input  if_re, if_addr, if_rlen, mem_re, mem_we, mem_addr, mem_len,
             mem_wdata, bus_ack, bus_rdata,
      output if_rack, if_rdata, mem_ack, mem_rdata, bus_re, bus_we,
             bus_addr, bus_len, bus_wdata, owner, busy, err
   );

   modport master (
      output if_re, if_addr, if_rlen, mem_re, mem_we, mem_addr, mem_len,
             mem_wdata, bus_ack, bus_rdata,
      input  if_rack, if_rdata, mem_ack, mem_rdata, bus_re, bus_we,
             bus_addr, bus_len, bus_wdata, owner, busy, err
   );

endinterface

// File: rtl/mem_port_arbiter_wdog.sv
// Bus watchdog: clear/enable cycle counter. expired is high during the
// enabled cycle whose increment would bring the count up to TIMEOUT.
module memarb_wdog #(
   parameter int TIMEOUT = 255,
   localparam int W = $clog2(TIMEOUT + 1)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);

   logic [W-1:0] count;

   // Count enabled cycles; clear has priority over enable
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count <= '0;
      else if (clr)
         count <= '0;
      else if (en)
         count <= count + 1'b1;
   end

   assign expired = en && (count == W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester memory bus arbiter (fetch vs. load/store) with a per-
// transaction watchdog. Define MEMARB_RR_EN for round-robin arbitration;
// otherwise mem has fixed priority over fetch.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_L  = 32,
   parameter int DATA_L  = 32,
   parameter int TIMEOUT = 255
) (
   input logic clk,
   input logic rst_n,
   mem_port_arbiter_if.slave io
);

   arb_state_t state;
   logic       if_req;
   logic       mem_req;
   logic       grant_mem;
   logic       wdog_expired;

   assign if_req  = io.if_re;
   assign mem_req = io.mem_re | io.mem_we;

`ifdef MEMARB_RR_EN
   // On a tie, whoever was not served last wins
   assign grant_mem = mem_req && (!if_req || (io.owner == OWNER_IF));
`else
   assign grant_mem = mem_req;
`endif

   memarb_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (state != ARB_GRANT),
      .en      (state == ARB_GRANT),
      .expired (wdog_expired)
   );

   // Arbitration FSM: latch winner into bus registers, wait for ack or
   // timeout, return data to the owner, then spend one dead cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ARB_IDLE;
         io.bus_re    <= 1'b0;
         io.bus_we    <= 1'b0;
         io.bus_addr  <= '0;
         io.bus_len   <= '0;
         io.bus_wdata <= '0;
         io.if_rack   <= 1'b0;
         io.if_rdata  <= '0;
         io.mem_ack   <= 1'b0;
         io.mem_rdata <= '0;
         io.owner     <= OWNER_IF;
         io.busy      <= 1'b0;
         io.err       <= 1'b0;
      end else begin
         io.if_rack <= 1'b0;
         io.mem_ack <= 1'b0;
         case (state)
            ARB_IDLE: begin
               if (if_req || mem_req) begin
                  state   <= ARB_GRANT;
                  io.busy <= 1'b1;
                  if (grant_mem) begin
                     io.owner     <= OWNER_MEM;
                     io.bus_addr  <= io.mem_addr;
                     io.bus_len   <= io.mem_len;
                     io.bus_wdata <= io.mem_wdata;
                     // a store wins when both mem strobes are set
                     io.bus_we    <= io.mem_we;
                     io.bus_re    <= ~io.mem_we;
                  end else begin
                     io.owner    <= OWNER_IF;
                     io.bus_addr <= io.if_addr;
                     io.bus_len  <= io.if_rlen;
                     io.bus_we   <= 1'b0;
                     io.bus_re   <= 1'b1;
                  end
               end
            end
            ARB_GRANT: begin
               if (io.bus_ack || wdog_expired) begin
                  state     <= ARB_RELEASE;
                  io.bus_re <= 1'b0;
                  io.bus_we <= 1'b0;
                  if (!io.bus_ack)
                     io.err <= 1'b1;
                  if (io.owner == OWNER_MEM) begin
                     io.mem_ack   <= 1'b1;
                     io.mem_rdata <= io.bus_ack ? io.bus_rdata : '0;
                  end else begin
                     io.if_rack   <= 1'b1;
                     io.if_rdata  <= io.bus_ack ? io.bus_rdata : '0;
                  end
               end
            end
            ARB_RELEASE: begin
               state   <= ARB_IDLE;
               io.busy <= 1'b0;
            end
            default: begin
               state     <= ARB_IDLE;
               io.busy   <= 1'b0;
               io.bus_re <= 1'b0;
               io.bus_we <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (TIMEOUT = 4).
// Honours MEMARB_RR_EN when choosing the expected tie-break order.
module tb_mem_port_arbiter;
   import mem_port_arbiter_pkg::*;

   localparam int TO = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   pass_cnt = 0;
   int   total_cnt = 0;

   mem_port_arbiter_if #(.ADDR_L(32), .DATA_L(32)) io ();

   mem_port_arbiter #(.ADDR_L(32), .DATA_L(32), .TIMEOUT(TO)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .io    (io)
   );

   always #5 clk = ~clk;

   // advance one rising edge; inputs driven and outputs sampled on negedge
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic test_reset();
      io.if_re = 0; io.if_addr = '0; io.if_rlen = LEN_WORD;
      io.mem_re = 0; io.mem_we = 0; io.mem_addr = '0; io.mem_len = '0;
      io.mem_wdata = '0; io.bus_ack = 0; io.bus_rdata = '0;
      rst_n = 0;
      tick(); tick();
      total_cnt++;
      if ({io.bus_re, io.bus_we, io.if_rack, io.mem_ack, io.owner, io.busy, io.err} !== 7'b0)
         $display("FAIL reset_flags: got %b want 0000000",
                  {io.bus_re, io.bus_we, io.if_rack, io.mem_ack, io.owner, io.busy, io.err});
      else pass_cnt++;
      total_cnt++;
      if ({io.bus_addr, io.bus_len, io.bus_wdata, io.if_rdata, io.mem_rdata} !== '0)
         $display("FAIL reset_data: addr %h len %0d wdata %h if_rdata %h mem_rdata %h want all 0",
                  io.bus_addr, io.bus_len, io.bus_wdata, io.if_rdata, io.mem_rdata);
      else pass_cnt++;
      rst_n = 1;
      tick();
      total_cnt++;
      if (io.busy !== 1'b0) $display("FAIL idle_no_req: busy %b want 0", io.busy);
      else pass_cnt++;
      $display("reset: done");
   endtask

   task automatic test_single_fetch();
      io.if_re = 1; io.if_addr = 32'h1000; io.if_rlen = LEN_WORD;
      tick();
      total_cnt++;
      if ({io.bus_re, io.bus_we, io.busy, io.if_rack} !== 4'b1010 ||
          io.bus_addr !== 32'h1000 || io.bus_len !== 2'd3)
         $display("FAIL fetch_grant: re/we/busy/rack %b addr %h len %0d want 1010 00001000 3",
                  {io.bus_re, io.bus_we, io.busy, io.if_rack}, io.bus_addr, io.bus_len);
      else pass_cnt++;
      io.bus_ack = 1; io.bus_rdata = 32'h0000_0013;
      tick();
      total_cnt++;
      if ({io.if_rack, io.bus_re, io.busy} !== 3'b101 || io.if_rdata !== 32'h13)
         $display("FAIL fetch_ack: rack/re/busy %b rdata %h want 101 00000013",
                  {io.if_rack, io.bus_re, io.busy}, io.if_rdata);
      else pass_cnt++;
      io.if_re = 0; io.bus_ack = 0;
      tick();
      total_cnt++;
      if ({io.if_rack, io.busy} !== 2'b00 || io.if_rdata !== 32'h13)
         $display("FAIL fetch_release: rack/busy %b rdata %h want 00 00000013",
                  {io.if_rack, io.busy}, io.if_rdata);
      else pass_cnt++;
      $display("single fetch: addr 00001000 rdata %h", io.if_rdata);
   endtask

   task automatic test_store_conflict();
      io.mem_re = 1; io.mem_we = 1; io.mem_addr = 32'h2004;
      io.mem_len = LEN_BYTE; io.mem_wdata = 32'hAB;
      tick();
      total_cnt++;
      if ({io.bus_we, io.bus_re, io.owner} !== 3'b101 || io.bus_len !== 2'd0 ||
          io.bus_wdata !== 32'hAB || io.bus_addr !== 32'h2004)
         $display("FAIL store_grant: we/re/owner %b len %0d wdata %h addr %h want 101 0 000000ab 00002004",
                  {io.bus_we, io.bus_re, io.owner}, io.bus_len, io.bus_wdata, io.bus_addr);
      else pass_cnt++;
      io.bus_ack = 1;
      tick();
      total_cnt++;
      if ({io.mem_ack, io.if_rack, io.bus_we} !== 3'b100)
         $display("FAIL store_ack: mem_ack/if_rack/we %b want 100",
                  {io.mem_ack, io.if_rack, io.bus_we});
      else pass_cnt++;
      io.mem_re = 0; io.mem_we = 0; io.bus_ack = 0;
      tick();
      total_cnt++;
      if (io.mem_ack !== 1'b0) $display("FAIL store_ack_pulse: mem_ack %b want 0", io.mem_ack);
      else pass_cnt++;
      $display("store: addr 00002004 wdata 000000ab");
   endtask

   task automatic test_simultaneous();
      logic first_mem;
`ifdef MEMARB_RR_EN
      first_mem = 1'b0;   // last owner was mem, so fetch wins the tie
`else
      first_mem = 1'b1;
`endif
      io.if_re = 1; io.if_addr = 32'h1100; io.if_rlen = LEN_WORD;
      io.mem_re = 1; io.mem_addr = 32'h3000; io.mem_len = LEN_WORD;
      tick();
      total_cnt++;
      if (io.owner !== first_mem || io.bus_addr !== (first_mem ? 32'h3000 : 32'h1100))
         $display("FAIL tie_first: owner %b addr %h want %b %h", io.owner, io.bus_addr,
                  first_mem, first_mem ? 32'h3000 : 32'h1100);
      else pass_cnt++;
      io.bus_ack = 1; io.bus_rdata = 32'hAAAA_0001;
      tick();
      total_cnt++;
      if ({io.mem_ack, io.if_rack} !== (first_mem ? 2'b10 : 2'b01))
         $display("FAIL tie_first_ack: mem_ack/if_rack %b want %b",
                  {io.mem_ack, io.if_rack}, first_mem ? 2'b10 : 2'b01);
      else pass_cnt++;
      if (first_mem) io.mem_re = 0; else io.if_re = 0;
      io.bus_ack = 0;
      tick();   // RELEASE -> IDLE
      tick();   // remaining request granted
      total_cnt++;
      if (io.owner !== ~first_mem || io.bus_addr !== (first_mem ? 32'h1100 : 32'h3000))
         $display("FAIL tie_second: owner %b addr %h want %b %h", io.owner, io.bus_addr,
                  ~first_mem, first_mem ? 32'h1100 : 32'h3000);
      else pass_cnt++;
      io.bus_ack = 1; io.bus_rdata = 32'hBBBB_0002;
      tick();
      total_cnt++;
      if (first_mem ? (io.if_rack !== 1'b1 || io.if_rdata !== 32'hBBBB_0002)
                    : (io.mem_ack !== 1'b1 || io.mem_rdata !== 32'hBBBB_0002))
         $display("FAIL tie_second_ack: if_rack %b if_rdata %h mem_ack %b mem_rdata %h want second ack with bbbb0002",
                  io.if_rack, io.if_rdata, io.mem_ack, io.mem_rdata);
      else pass_cnt++;
      io.if_re = 0; io.mem_re = 0; io.bus_ack = 0;
      tick();
      $display("simultaneous: first owner %b", first_mem);
   endtask

   task automatic test_watchdog();
      io.if_re = 1; io.if_addr = 32'h4000;
      tick();
      for (int i = 1; i < TO; i++) begin
         tick();
         total_cnt++;
         if ({io.if_rack, io.bus_re, io.err} !== 3'b010)
            $display("FAIL wdog_wait%0d: rack/re/err %b want 010", i,
                     {io.if_rack, io.bus_re, io.err});
         else pass_cnt++;
      end
      tick();
      total_cnt++;
      if ({io.if_rack, io.bus_re, io.err} !== 3'b101 || io.if_rdata !== 32'h0)
         $display("FAIL wdog_expire: rack/re/err %b rdata %h want 101 00000000",
                  {io.if_rack, io.bus_re, io.err}, io.if_rdata);
      else pass_cnt++;
      io.if_re = 0; io.bus_ack = 1; io.bus_rdata = 32'hDEAD_BEEF;   // late ack
      tick();
      io.bus_ack = 0;
      total_cnt++;
      if ({io.if_rack, io.mem_ack, io.busy, io.err} !== 4'b0001 || io.if_rdata !== 32'h0)
         $display("FAIL wdog_late_ack: rack/mack/busy/err %b rdata %h want 0001 00000000",
                  {io.if_rack, io.mem_ack, io.busy, io.err}, io.if_rdata);
      else pass_cnt++;
      io.mem_re = 1; io.mem_addr = 32'h5000; io.mem_len = LEN_HALF;
      tick();
      io.bus_ack = 1; io.bus_rdata = 32'h55;
      tick();
      total_cnt++;
      if ({io.mem_ack, io.err} !== 2'b11 || io.mem_rdata !== 32'h55)
         $display("FAIL wdog_after: mem_ack/err %b rdata %h want 11 00000055",
                  {io.mem_ack, io.err}, io.mem_rdata);
      else pass_cnt++;
      io.mem_re = 0; io.bus_ack = 0;
      tick();
      $display("watchdog: timeout after %0d grant cycles, err %b", TO, io.err);
   endtask

   task automatic test_stray_ack();
      io.bus_ack = 1; io.bus_rdata = 32'h7777_7777;
      tick();
      tick();
      total_cnt++;
      if ({io.if_rack, io.mem_ack, io.busy, io.bus_re, io.bus_we} !== 5'b0 ||
          io.mem_rdata !== 32'h55)
         $display("FAIL stray_ack: rack/mack/busy/re/we %b mem_rdata %h want 00000 00000055",
                  {io.if_rack, io.mem_ack, io.busy, io.bus_re, io.bus_we}, io.mem_rdata);
      else pass_cnt++;
      io.bus_ack = 0;
      $display("stray ack: ignored");
   endtask

   task automatic test_reset_mid();
      io.if_re = 1; io.if_addr = 32'h6000;
      tick();
      total_cnt++;
      if (io.bus_re !== 1'b1) $display("FAIL mid_grant: bus_re %b want 1", io.bus_re);
      else pass_cnt++;
      #2 rst_n = 0;
      #1;
      total_cnt++;
      if ({io.bus_re, io.bus_we, io.if_rack, io.mem_ack, io.busy, io.err} !== 6'b0)
         $display("FAIL mid_reset: re/we/rack/mack/busy/err %b want 000000",
                  {io.bus_re, io.bus_we, io.if_rack, io.mem_ack, io.busy, io.err});
      else pass_cnt++;
      tick();
      rst_n = 1;
      tick();
      total_cnt++;
      if ({io.bus_re, io.owner, io.busy} !== 3'b101 || io.bus_addr !== 32'h6000)
         $display("FAIL post_reset_grant: re/owner/busy %b addr %h want 101 00006000",
                  {io.bus_re, io.owner, io.busy}, io.bus_addr);
      else pass_cnt++;
      io.bus_ack = 1; io.bus_rdata = 32'h66;
      tick();
      total_cnt++;
      if ({io.if_rack, io.err} !== 2'b10 || io.if_rdata !== 32'h66)
         $display("FAIL post_reset_ack: rack/err %b rdata %h want 10 00000066",
                  {io.if_rack, io.err}, io.if_rdata);
      else pass_cnt++;
      io.if_re = 0; io.bus_ack = 0;
      tick();
      $display("reset mid-transaction: recovered, rdata %h", io.if_rdata);
   endtask

   initial begin
      test_reset();
      test_single_fetch();
      test_store_conflict();
      test_simultaneous();
      test_watchdog();
      test_stray_ack();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter sharing the single memory bus between the instruction-fetch stage (read-only, word fetches) and the memory-access stage (loads and stores). Sits between the pipeline stages and the memory model/controller. Converts each stage's level request into a bus transaction, returns a one-cycle acknowledge with latched read data, and guards every bus transaction with a watchdog so a stage can never hang on a missing bus acknowledge.

## Interface
Parameters:
- ADDR_L, 32: address width.
- DATA_L, 32: data width.
- TIMEOUT, 255: maximum cycles to wait for `bus_ack`; must be ≥1.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- if_re  in  1  fetch read request, level; held until `if_rack`.
- if_addr  in  ADDR_L  fetch address; stable while `if_re`=1.
- if_rlen  in  2  fetch length code; the fetch stage drives 3 (word).
- if_rack  out  1  one-cycle fetch acknowledge.
- if_rdata  out  DATA_L  fetch data; valid when `if_rack`=1 and held until the next fetch ack.
- mem_re  in  1  load request, level.
- mem_we  in  1  store request, level.
- mem_addr  in  ADDR_L  load/store address.
- mem_len  in  2  length code: 0 byte, 1 half, 3 word (2 reserved, forwarded unchanged).
- mem_wdata  in  DATA_L  store data.
- mem_ack  out  1  one-cycle load/store acknowledge.
- mem_rdata  out  DATA_L  load data; valid when `mem_ack`=1.
- bus_re, bus_we  out  1  bus read and write strobes, held for the whole transaction.
- bus_addr  out  ADDR_L  bus address.
- bus_len  out  2  bus length code.
- bus_wdata  out  DATA_L  bus write data.
- bus_ack  in  1  bus completion pulse.
- bus_rdata  in  DATA_L  bus read data; valid with `bus_ack`.
- owner  out  1  current or last grant: 0 = fetch, 1 = mem.
- busy  out  1  high in GRANT or RELEASE.
- err  out  1  sticky watchdog-timeout flag.

## Operation
- State machine with states IDLE, GRANT, RELEASE.
- IDLE: samples requests. If no request is pending, the state stays IDLE.
- If a request is pending, the arbiter latches the winner's address, length, write data and direction into the bus registers. It sets `owner` and moves to GRANT.
- GRANT: bus strobes are held. Each cycle the watchdog counter increments.
  - On `bus_ack`, the arbiter latches `bus_rdata` into the owner's rdata register and pulses the owner's ack. It drops the strobes and moves to RELEASE.
  - If the counter reaches TIMEOUT with no ack, the arbiter sets `err`, pulses the owner's ack with rdata = 0, drops the strobes and moves to RELEASE.
- RELEASE: one dead cycle, then return to IDLE. A requester must deassert its request on the cycle its ack is high. A request still high in IDLE is treated as a new request.
- Priority (without the configuration macro): mem beats fetch when both are pending.
- If `mem_re` and `mem_we` are both high, the transaction is a write and `bus_re` stays 0.
- `bus_ack` in IDLE or RELEASE is ignored. A late ack arriving after a timeout is dropped.
- Inputs changing during GRANT have no effect, because the bus registers are already latched.
- `err` clears only on reset.

## Timing
- Reset values: all strobes, acks, `owner`, `busy` and `err` are 0. All data and address outputs are 0. State is IDLE. The watchdog is 0.
- Reset mid-transaction: strobes drop immediately and asynchronously, and the in-flight transaction is abandoned.
- All outputs are registered.
- Request high before edge k (state IDLE):
  - edge k: strobes and `busy` high.
  - `bus_ack` high before edge k+n: requester ack high for the cycle after edge k+n, and strobes low in that same cycle.
  - edge k+n+1: RELEASE → IDLE.
- Minimum request-to-ack latency: 2 cycles with a single-cycle bus.
- Back-to-back requests are serviced every 3 cycles.
- Timeout: the ack is forced in the cycle after the TIMEOUT-th GRANT cycle that has no `bus_ack`.

## Configuration
- `MEMARB_RR_EN` defined: round-robin arbitration. When both are pending, the requester not served last wins, tracked by `owner`.
- `MEMARB_RR_EN` undefined: fixed priority, mem over fetch.
- A single pending request is always granted immediately in both modes.

## Structure
- The shared constants header holds:
  - length codes LEN_BYTE=0, LEN_HALF=1, LEN_WORD=3;
  - state encodings ARB_IDLE, ARB_GRANT, ARB_RELEASE;
  - the owner codes.
- One sub-module, `memarb_wdog`: a clear/enable counter of width $clog2(TIMEOUT+1) with an `expired` output.

## Test plan
- **Single fetch.** Stimulus: `if_re`=1, `if_addr`=0x1000, bus ack 1 cycle after strobe with rdata 0x00000013. Required response: `bus_addr`=0x1000, `bus_len`=3, `if_rack` pulse exactly one cycle, `if_rdata`=0x00000013, `busy` drops 2 cycles later.
- **Simultaneous requests.** Stimulus: `if_re` and `mem_re`=1 in the same cycle, without RR. Required response: mem served first, then fetch. With `MEMARB_RR_EN` and last owner = mem, fetch is served first.
- **Store with conflicting strobes.** Stimulus: `mem_we`=`mem_re`=1, addr 0x2004, `mem_len`=0, wdata 0xAB. Required response: `bus_we`=1, `bus_re`=0, `bus_len`=0, `bus_wdata`=0xAB, `mem_ack` pulse.
- **Watchdog timeout.** Stimulus: TIMEOUT=4, no `bus_ack`. Required response: `if_rack` pulse after 4 GRANT cycles with `if_rdata`=0 and `err`=1 sticky. A late `bus_ack` is ignored, and the next request completes normally with `err` still 1.
- **Reset mid-transaction.** Stimulus: `rst_n` low during GRANT. Required response: strobes, acks and `err` are 0 asynchronously, and the first request after release of reset is granted normally.
- **Stray bus ack.** Stimulus: `bus_ack` pulsed in IDLE. Required response: no requester ack and no state change.
